// File: rtl/bdu_pkg.sv
// Shared definitions for the bit-serial distance unit and its sequencer.
package bdu_pkg;
    localparam int W    = 16;
    localparam int ID_W = 8;

    localparam logic [1:0] CODE_IDLE = 2'b00;
    localparam logic [1:0] CODE_X    = 2'b01;
    localparam logic [1:0] CODE_Y    = 2'b10;
    localparam logic [1:0] CODE_Z    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_OUT
    } state_t;
endpackage

// File: rtl/bdu_sat_cnt.sv
// Up-counter with increment enable that holds at all-ones instead of wrapping.
module bdu_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);
    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/bdu_ctrl.sv
// Sequencer that streams query/candidate bits MSB-first into an external BDU,
// honours early termination at bit-group boundaries and returns the distance.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  IDLE     | in_ready high, waiting for a job
//  CLEAR    | one cycle, clears the BDU accumulators
//  STREAM   | one BDU step per cycle, x,y,z per bit, MSB first
//  DRAIN    | one cycle, captures the BDU distance
//  OUT      | result presented until out_ready
module bdu_ctrl #(
    parameter int W    = bdu_pkg::W,
    parameter int ID_W = bdu_pkg::ID_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    q_x,
    input  logic [W-1:0]    q_y,
    input  logic [W-1:0]    q_z,
    input  logic [W-1:0]    r_x,
    input  logic [W-1:0]    r_y,
    input  logic [W-1:0]    r_z,
    input  logic [ID_W-1:0] in_id,
    input  logic [2*W-1:0]  in_thresh,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_id,
    output logic [2*W-1:0]  out_dist,
    output logic            out_pruned,
    output logic            bdu_clr,
    output logic            bdu_q_bit,
    output logic            bdu_r_bit,
    output logic [1:0]      bdu_code,
    output logic [6:0]      bdu_which_bit,
    output logic [2*W-1:0]  bdu_thresh,
    input  logic            bdu_terminate,
    input  logic [2*W-1:0]  bdu_dist,
    output logic [15:0]     cnt_done,
    output logic [15:0]     cnt_pruned
);
    import bdu_pkg::*;

    localparam int BW = $clog2(W);

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_lat_qx, r_lat_qy, r_lat_qz;
    logic [W-1:0]    r_lat_rx, r_lat_ry, r_lat_rz;
    logic [ID_W-1:0] r_id;
    logic [2*W-1:0]  r_thresh;
    logic [2*W-1:0]  r_dist;
    logic            r_pruned;
    logic [BW-1:0]   r_bit;
    logic [1:0]      r_dim;
    logic            w_accept;
    logic            w_term;
    logic            w_last;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    // Terminate is only meaningful once a whole x,y,z group has been absorbed.
    assign w_term   = (r_state == ST_STREAM) && (r_dim == CODE_X)
                      && (r_bit != BW'(W-1)) && bdu_terminate;
    assign w_last   = (r_dim == CODE_Z) && (r_bit == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        bdu_clr       = !rst;
        bdu_code      = CODE_IDLE;
        bdu_q_bit     = 1'b0;
        bdu_r_bit     = 1'b0;
        bdu_which_bit = '0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                bdu_clr = 1'b1;
                w_next  = ST_STREAM;
            end
            ST_STREAM: begin
                bdu_code      = r_dim;
                bdu_which_bit = 7'({r_bit, 1'b0});
                case (r_dim)
                    CODE_X: begin
                        bdu_q_bit = r_lat_qx[r_bit];
                        bdu_r_bit = r_lat_rx[r_bit];
                    end
                    CODE_Y: begin
                        bdu_q_bit = r_lat_qy[r_bit];
                        bdu_r_bit = r_lat_ry[r_bit];
                    end
                    default: begin
                        bdu_q_bit = r_lat_qz[r_bit];
                        bdu_r_bit = r_lat_rz[r_bit];
                    end
                endcase
                if (w_term)      w_next = ST_OUT;
                else if (w_last) w_next = ST_DRAIN;
            end
            ST_DRAIN: w_next = ST_OUT;
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lat_qx <= '0;  r_lat_qy <= '0;  r_lat_qz <= '0;
            r_lat_rx <= '0;  r_lat_ry <= '0;  r_lat_rz <= '0;
            r_id     <= '0;
            r_thresh <= '0;
            r_dist   <= '0;
            r_pruned <= 1'b0;
            r_bit    <= '0;
            r_dim    <= CODE_IDLE;
        end else begin
            if (w_accept) begin
                r_lat_qx <= q_x;  r_lat_qy <= q_y;  r_lat_qz <= q_z;
                r_lat_rx <= r_x;  r_lat_ry <= r_y;  r_lat_rz <= r_z;
                r_id     <= in_id;
                r_thresh <= in_thresh;
            end
            case (r_state)
                ST_CLEAR: begin
                    r_bit <= BW'(W-1);
                    r_dim <= CODE_X;
                end
                ST_STREAM: begin
                    if (w_term) begin
                        r_dist   <= '0;
                        r_pruned <= 1'b1;
                    end else if (!w_last) begin
                        if (r_dim == CODE_Z) begin
                            r_dim <= CODE_X;
                            r_bit <= r_bit - BW'(1);
                        end else begin
                            r_dim <= r_dim + 2'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_dist   <= bdu_dist;
                    r_pruned <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_id     = r_id;
    assign out_dist   = r_dist;
    assign out_pruned = r_pruned;
    assign bdu_thresh = r_thresh;

    bdu_sat_cnt #(.WIDTH(16)) u_cnt_done (
        .clk   (clk),
        .rst   (rst),
        .i_inc (out_valid && out_ready && !r_pruned),
        .o_cnt (cnt_done)
    );

    bdu_sat_cnt #(.WIDTH(16)) u_cnt_pruned (
        .clk   (clk),
        .rst   (rst),
        .i_inc (out_valid && out_ready && r_pruned),
        .o_cnt (cnt_pruned)
    );
endmodule
